// File: rtl/conv_33_stream_if.sv
// Ready/valid stream bundle for conv_33_stream: raster pixels in, convolution results out.
interface conv_33_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_33_stream.sv
// Streaming 3x3 convolution: walks the zero-padded grid in raster order, keeps two line
// buffers plus a 3x2 window, and emits saturated (optionally ReLU'd) results at stride 1 or 2.
module conv_33_stream #(
  parameter int unsigned IMG_W      = 220,
  parameter int unsigned IMG_H      = 220,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PAD        = 1,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [9*DATA_WIDTH-1:0] kernel,
  input  logic                    relu_en,
  conv_33_stream_if.slave         bus,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned GW     = IMG_W + 2 * PAD;
  localparam int unsigned GH     = IMG_H + 2 * PAD;
  localparam int unsigned OUT_W  = (GW - 3) / STRIDE + 1;
  localparam int unsigned OUT_H  = (GH - 3) / STRIDE + 1;
  localparam int unsigned LAST_C = (OUT_W - 1) * STRIDE + 2;
  localparam int unsigned LAST_R = (OUT_H - 1) * STRIDE + 2;
  localparam int unsigned CW     = $clog2(GW);
  localparam int unsigned RW     = $clog2(GH);
  localparam int unsigned PW     = 2 * DW;
  localparam int unsigned ACC_W  = 2 * DW + 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic signed [DW-1:0] lb0 [GW];
  logic signed [DW-1:0] lb1 [GW];
  logic signed [DW-1:0] win [3][2];
  logic signed [DW-1:0] k_q [9];
  logic                 relu_q;
  logic                 last_acc;

  logic                    col_real, row_real, pos_real, slot_free, step, emit;
  logic                    at_last_out, grid_end, out_fire;
  logic signed [DW-1:0]    pix;
  logic signed [DW-1:0]    newcol [3];
  logic signed [DW-1:0]    g [3][3];
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-DW:0]       acc_hi;
  logic signed [DW-1:0]    sat, res;

  // Pad positions are free steps; real positions need an input beat.
  assign col_real    = (PAD == 0) || ((col != '0) && (col != CW'(GW - 1)));
  assign row_real    = (PAD == 0) || ((row != '0) && (row != RW'(GH - 1)));
  assign pos_real    = col_real && row_real;
  assign slot_free   = !bus.out_valid || bus.out_ready;
  assign step        = (state == RUN) && slot_free && (!pos_real || bus.in_valid);
  assign bus.in_ready = (state == RUN) && pos_real && slot_free;
  assign pix         = pos_real ? bus.in_data : '0;
  assign emit        = (row >= RW'(2)) && (col >= CW'(2)) &&
                       ((STRIDE == 1) || (!row[0] && !col[0]));
  assign at_last_out = (row == RW'(LAST_R)) && (col == CW'(LAST_C));
  assign grid_end    = (row == RW'(GH - 1)) && (col == CW'(GW - 1));
  assign out_fire    = bus.out_valid && bus.out_ready;

  // Window MAC uses the incoming column directly so the result registers on the step itself.
  always_comb begin
    newcol[0] = lb1[col];
    newcol[1] = lb0[col];
    newcol[2] = pix;
    acc  = '0;
    prod = '0;
    for (int r = 0; r < 3; r++) begin
      g[r][0] = win[r][0];
      g[r][1] = win[r][1];
      g[r][2] = newcol[r];
      for (int c = 0; c < 3; c++) begin
        prod = PW'(g[r][c]) * PW'(k_q[3*r+c]);
        acc  = acc + ACC_W'(prod);
      end
    end
    acc_hi = acc[ACC_W-1:DW-1];
    if ((acc_hi == '0) || (acc_hi == '1)) sat = acc[DW-1:0];
    else if (acc[ACC_W-1])                sat = {1'b1, {(DW-1){1'b0}}};
    else                                  sat = {1'b0, {(DW-1){1'b1}}};
    res = (relu_q && sat[DW-1]) ? '0 : sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      relu_q        <= 1'b0;
      last_acc      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      for (int i = 0; i < GW; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
      for (int i = 0; i < 9; i++) k_q[i] <= '0;
    end else begin
      done <= 1'b0;
      if (out_fire) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        if (bus.out_last) last_acc <= 1'b1;
      end
      if (step && emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res;
        bus.out_last  <= at_last_out;
      end
      if (step) begin
        lb1[col] <= lb0[col];
        lb0[col] <= pix;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= newcol[r];
        end
        if (grid_end) begin
          col <= '0;
          row <= '0;
        end else if (col == CW'(GW - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          last_acc <= 1'b0;
          relu_q   <= relu_en;
          row      <= '0;
          col      <= '0;
          for (int i = 0; i < 9; i++) k_q[i] <= kernel[DW*i +: DW];
        end
        RUN: if (step && grid_end) state <= DRAIN;
        DRAIN: if (last_acc || (out_fire && bus.out_last)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
